// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multicycle instruction-sequencing controller.
//
// Walks every instruction through FETCH -> DECODE -> EXEC -> [MEM] -> [WB]
// and produces the datapath enables and mux selects. Mux selects are decoded
// from the instruction register in every state. Enables are asserted only in
// the states that use them. Illegal classes park the FSM in TRAP until reset.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   inst[31:0]              memory read data, captured into ir in FETCH
//   mem_ready               memory access completes this cycle
//   cmd_flag                ALU condition result for branches
//   src_index1/2, dst_index register indices (ir[19:16] / ir[15:12] / ir[23:20])
//   imm[15:0]               immediate field ir[15:0]
//   alu_op[4:0], alu_mux, dstdata_mux, nextpc_mux   datapath selects
//   mem_rd_en, mem_wrt_en, reg_wrt_en, pc_wrt_en, ir_load   enables
//   state[2:0], trap        current FSM state, sticky error flag
//
// Option: MULTICYCLE_CTRL_MEM_TIMEOUT_EN adds an 8-bit wait counter. It traps
// a memory access in FETCH or MEM after 255 consecutive not-ready cycles.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        cmd_flag,
  output logic [3:0]  src_index1,
  output logic [3:0]  src_index2,
  output logic [3:0]  dst_index,
  output logic [15:0] imm,
  output logic [4:0]  alu_op,
  output logic [1:0]  alu_mux,
  output logic [1:0]  dstdata_mux,
  output logic [1:0]  nextpc_mux,
  output logic        mem_rd_en,
  output logic        mem_wrt_en,
  output logic        reg_wrt_en,
  output logic        pc_wrt_en,
  output logic        ir_load,
  output logic [2:0]  state,
  output logic        trap
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  cls;
  logic        is_alu, is_cmp, is_lw, is_sw, is_br, is_jal, legal;
  logic        rd, wr, rw, pw, ld;
  logic        timeout;

  assign cls    = ir_q[31:28];
  assign is_alu = (cls == 4'hC) || (cls == 4'h4);
  assign is_cmp = (cls == 4'hD) || (cls == 4'h5);
  assign is_lw  = (cls == 4'h7);
  assign is_sw  = (cls == 4'h3);
  assign is_br  = (cls == 4'h2);
  assign is_jal = (cls == 4'h6);
  assign legal  = is_alu | is_cmp | is_lw | is_sw | is_br | is_jal;

  assign src_index1 = ir_q[19:16];
  assign src_index2 = ir_q[15:12];
  assign dst_index  = ir_q[23:20];
  assign imm        = ir_q[15:0];

  always_comb begin
    alu_op      = 5'b00000;
    alu_mux     = 2'b00;
    dstdata_mux = 2'b00;
    nextpc_mux  = 2'b00;
    if (is_alu) alu_op = {1'b0, ir_q[27:24]};
    if (is_cmp || is_br) alu_op = {1'b1, ir_q[27:24]};
    if (is_lw || is_sw || is_jal) alu_op = 5'b00001;
    if (cls == 4'h4 || cls == 4'h5 || is_lw || is_sw || is_jal) alu_mux = 2'b01;
    if (is_lw)  dstdata_mux = 2'b01;
    if (is_jal) dstdata_mux = 2'b10;
    // Branch target is only taken when the ALU condition holds.
    if (is_br)  nextpc_mux = cmd_flag ? 2'b01 : 2'b00;
    if (is_jal) nextpc_mux = 2'b10;
  end

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;

  assign timeout = (wait_q == 8'hFF);

  // Any state change clears the count, so it restarts on entry to FETCH/MEM.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)
      wait_d = 8'd0;
    else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
      wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_q <= 8'd0;
    else       wait_q <= wait_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rd = 1'b0;
    wr = 1'b0;
    rw = 1'b0;
    pw = 1'b0;
    ld = 1'b0;
    case (state_q)
      S_FETCH: begin
        rd = 1'b1;
        if (timeout) state_d = S_TRAP;
        else if (mem_ready) begin
          ld      = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_br) begin
          pw      = 1'b1;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) state_d = S_MEM;
        else                         state_d = S_WB;
      end
      S_MEM: begin
        rd = is_lw;
        wr = is_sw;
        if (timeout) state_d = S_TRAP;
        else if (mem_ready) begin
          pw      = is_sw;
          state_d = is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        rw      = 1'b1;
        pw      = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  assign ir_d = ld ? inst : ir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Reset kills enables combinationally so an aborted access never writes.
  assign mem_rd_en  = rd & ~reset;
  assign mem_wrt_en = wr & ~reset;
  assign reg_wrt_en = rw & ~reset;
  assign pc_wrt_en  = pw & ~reset;
  assign ir_load    = ld & ~reset;
  assign state      = state_q;
  assign trap       = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic        mem_ready, cmd_flag;
  logic [3:0]  src_index1, src_index2, dst_index;
  logic [15:0] imm;
  logic [4:0]  alu_op;
  logic [1:0]  alu_mux, dstdata_mux, nextpc_mux;
  logic        mem_rd_en, mem_wrt_en, reg_wrt_en, pc_wrt_en, ir_load;
  logic [2:0]  state;
  logic        trap;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .inst(inst), .mem_ready(mem_ready), .cmd_flag(cmd_flag),
    .src_index1(src_index1), .src_index2(src_index2), .dst_index(dst_index), .imm(imm),
    .alu_op(alu_op), .alu_mux(alu_mux), .dstdata_mux(dstdata_mux), .nextpc_mux(nextpc_mux),
    .mem_rd_en(mem_rd_en), .mem_wrt_en(mem_wrt_en), .reg_wrt_en(reg_wrt_en),
    .pc_wrt_en(pc_wrt_en), .ir_load(ir_load), .state(state), .trap(trap)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  // One expected cycle: state, enables {rd,wr,reg,pc,ld}, mem_ready to drive,
  // and whether the decoded fields already reflect the new instruction.
  typedef struct {
    int         st;
    logic [4:0] en;
    logic       rdy;
    logic       chk;
  } exp_t;

  exp_t        q[$];
  logic [31:0] cur_inst;
  logic        cur_flag;

  // Expected decoded fields straight from the instruction-class table.
  function automatic logic [38:0] exp_fields(input logic [31:0] i, input logic f);
    logic [4:0] aop;
    logic [1:0] amux, dmux, npc;
    aop = 5'd0; amux = 2'd0; dmux = 2'd0; npc = 2'd0;
    case (i[31:28])
      4'hC: aop = {1'b0, i[27:24]};
      4'h4: begin aop = {1'b0, i[27:24]}; amux = 2'd1; end
      4'hD: aop = {1'b1, i[27:24]};
      4'h5: begin aop = {1'b1, i[27:24]}; amux = 2'd1; end
      4'h2: begin aop = {1'b1, i[27:24]}; npc = f ? 2'd1 : 2'd0; end
      4'h7: begin aop = 5'd1; amux = 2'd1; dmux = 2'd1; end
      4'h3: begin aop = 5'd1; amux = 2'd1; end
      4'h6: begin aop = 5'd1; amux = 2'd1; dmux = 2'd2; npc = 2'd2; end
      default: ;
    endcase
    return {i[19:16], i[15:12], i[23:20], i[15:0], aop, amux, dmux, npc};
  endfunction

  function automatic exp_t mk(input int st, input logic [4:0] en, input logic rdy, input logic chk);
    exp_t e;
    e.st = st; e.en = en; e.rdy = rdy; e.chk = chk;
    return e;
  endfunction

  // Cycle-by-cycle expectation derived from the class and wait counts.
  task automatic build(input logic [31:0] i, input int fw, input int mw, input logic f);
    logic [3:0] c;
    logic       r;
    c = i[31:28];
    cur_inst = i;
    cur_flag = f;
    q.delete();
    for (int k = 0; k < fw; k++) q.push_back(mk(0, 5'b10000, 1'b0, 1'b0));
    q.push_back(mk(0, 5'b10001, 1'b1, 1'b0));
    r = 1'($urandom_range(0, 1));
    q.push_back(mk(1, 5'b00000, r, 1'b1));
    if (!(c inside {4'hC, 4'h4, 4'hD, 4'h5, 4'h7, 4'h3, 4'h2, 4'h6})) begin
      for (int k = 0; k < 3; k++) q.push_back(mk(7, 5'b00000, 1'($urandom_range(0, 1)), 1'b1));
      return;
    end
    r = 1'($urandom_range(0, 1));
    if (c == 4'h2) begin
      q.push_back(mk(2, 5'b00010, r, 1'b1));
      return;
    end
    q.push_back(mk(2, 5'b00000, r, 1'b1));
    if (c == 4'h7 || c == 4'h3) begin
      for (int k = 0; k < mw; k++)
        q.push_back(mk(3, (c == 4'h7) ? 5'b10000 : 5'b01000, 1'b0, 1'b1));
      q.push_back(mk(3, (c == 4'h7) ? 5'b10000 : 5'b01010, 1'b1, 1'b1));
      if (c == 4'h3) return;
    end
    q.push_back(mk(4, 5'b00110, 1'($urandom_range(0, 1)), 1'b1));
  endtask

  // Plays the first n expected cycles; entered and left at a falling edge.
  task automatic play(input int n);
    exp_t        e;
    logic [4:0]  en_act;
    logic [38:0] f_exp, f_act;
    for (int k = 0; k < n && k < q.size(); k++) begin
      e = q[k];
      mem_ready = e.rdy;
      cmd_flag  = cur_flag;
      inst      = (e.st == 0) ? cur_inst : $urandom;
      #1;
      en_act = {mem_rd_en, mem_wrt_en, reg_wrt_en, pc_wrt_en, ir_load};
      total++;
      if (state !== 3'(e.st)) begin
        bad++;
        $display("FAIL state inst=%h cyc=%0d got=%0d exp=%0d", cur_inst, k, state, e.st);
      end
      total++;
      if (en_act !== e.en) begin
        bad++;
        $display("FAIL enables inst=%h cyc=%0d got=%b exp=%b", cur_inst, k, en_act, e.en);
      end
      total++;
      if (trap !== (e.st == 7)) begin
        bad++;
        $display("FAIL trap inst=%h cyc=%0d got=%b exp=%b", cur_inst, k, trap, e.st == 7);
      end
      if (e.chk) begin
        f_exp = exp_fields(cur_inst, cur_flag);
        f_act = {src_index1, src_index2, dst_index, imm, alu_op, alu_mux, dstdata_mux, nextpc_mux};
        total++;
        if (f_act !== f_exp) begin
          bad++;
          $display("FAIL fields inst=%h cyc=%0d got=%h exp=%h", cur_inst, k, f_act, f_exp);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic run_inst(input logic [31:0] i, input int fw, input int mw, input logic f);
    build(i, fw, mw, f);
    play(q.size());
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    total++;
    if (state !== 3'd0 || trap !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got=%0d/%b exp=0/0", state, trap);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; cmd_flag = 1'b0; inst = 32'hC0123000;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if ({state, trap} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_state got=%0d/%b exp=0/0", state, trap);
    end
    total++;
    if ({mem_rd_en, mem_wrt_en, reg_wrt_en, pc_wrt_en, ir_load} !== 5'b0) begin
      bad++;
      $display("FAIL reset_enables got=%b exp=00000",
               {mem_rd_en, mem_wrt_en, reg_wrt_en, pc_wrt_en, ir_load});
    end
    total++;
    if ({src_index1, src_index2, dst_index, imm} !== 28'd0) begin
      bad++;
      $display("FAIL reset_ir got=%h exp=0", {src_index1, src_index2, dst_index, imm});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_inst(32'hC0123000, 0, 0, 1'b0);   // ALU-R
    run_inst(32'h7012000C, 0, 2, 1'b0);   // LW, two MEM waits
    run_inst(32'h20120004, 0, 0, 1'b1);   // BR taken
    run_inst(32'h20120004, 0, 0, 1'b0);   // BR not taken
    run_inst(32'h3012000C, 2, 1, 1'b0);   // SW with fetch and mem waits
    run_inst(32'h6A50BEEF, 1, 0, 1'b1);   // JAL
  endtask

  task automatic test_random();
    logic [3:0] cls_tab [8];
    logic [31:0] i;
    cls_tab = '{4'hC, 4'h4, 4'hD, 4'h5, 4'h7, 4'h3, 4'h2, 4'h6};
    for (int n = 0; n < 40; n++) begin
      i = $urandom;
      i[31:28] = cls_tab[$urandom_range(0, 7)];
      run_inst(i, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_trap();
    run_inst(32'hF0000000, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'b1;
      #1;
      total++;
      if (state !== 3'd7 || trap !== 1'b1 ||
          {mem_rd_en, mem_wrt_en, reg_wrt_en, pc_wrt_en, ir_load} !== 5'b0) begin
        bad++;
        $display("FAIL trap_hold got state=%0d trap=%b en=%b exp 7/1/00000", state, trap,
                 {mem_rd_en, mem_wrt_en, reg_wrt_en, pc_wrt_en, ir_load});
      end
      @(negedge clk);
    end
    pulse_reset();
    run_inst(32'h4A31_0042, 0, 0, 1'b0);  // recovery after trap
  endtask

  task automatic test_reset_mid();
    build(32'h3012000C, 0, 3, 1'b0);
    play(4);                              // through the first MEM wait cycle
    reset = 1'b1;
    #1;
    total++;
    if (mem_wrt_en !== 1'b0 || pc_wrt_en !== 1'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid got wr=%b pc=%b state=%0d exp 0/0/0", mem_wrt_en, pc_wrt_en, state);
    end
    @(negedge clk);
    reset = 1'b0;
    run_inst(32'hD1234567, 0, 0, 1'b0);
  endtask

  task automatic test_wait_bound();
    int  cyc;
    logic seen_ld;
    pulse_reset();
    mem_ready = 1'b0;
    cyc = 0;
    seen_ld = 1'b0;
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    while (state !== 3'd7 && cyc < 400) begin
      #1;
      if (ir_load === 1'b1) seen_ld = 1'b1;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc != 256 || seen_ld) begin
      bad++;
      $display("FAIL timeout got cycles=%0d ld=%b exp 256/0", cyc, seen_ld);
    end
    pulse_reset();
`else
    for (int k = 0; k < 300; k++) begin
      #1;
      if (ir_load === 1'b1 || state !== 3'd0) seen_ld = 1'b1;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (seen_ld) begin
      bad++;
      $display("FAIL unbounded_wait left FETCH within %0d cycles", cyc);
    end
`endif
    run_inst(32'h5F00_1234, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_trap();
    test_reset_mid();
    test_wait_bound();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous active-high reset.
- inst  in  32  memory read data, captured as the instruction in FETCH.
- mem_ready  in  1  memory handshake: access complete this cycle.
- cmd_flag  in  1  ALU condition result for the branch decision.
- src_index1/src_index2/dst_index  out  4 each  ir[19:16] / ir[15:12] / ir[23:20].
- imm  out  16  ir[15:0].
- alu_op  out  5  ALU function select.
- alu_mux  out  2  00 = register B, 01 = imm.
- dstdata_mux  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- nextpc_mux  out  2  00 = PC+4, 01 = branch target, 10 = ALU result.
- mem_rd_en, mem_wrt_en, reg_wrt_en, pc_wrt_en, ir_load  out  1 each  enables.
- state  out  3  current FSM state.
- trap  out  1  sticky error flag.

Function
REQ-003 The instruction class SHALL be ir[31:28]: 1100 ALU-R, 0100 ALU-I, 1101 CMP-R, 0101 CMP-I, 0111 LW, 0011 SW, 0010 BR, 0110 JAL; any other value is illegal.
REQ-004 alu_op SHALL be {0, ir[27:24]} for ALU classes, {1, ir[27:24]} for CMP and BR, and 5'b00001 (add) for LW, SW and JAL.
REQ-005 alu_mux SHALL be 01 for ALU-I, CMP-I, LW, SW and JAL, and 00 otherwise.
REQ-006 The state encoding SHALL be FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4 and TRAP = 7.
REQ-007 In FETCH the block SHALL hold mem_rd_en = 1 until mem_ready = 1; in that cycle ir_load = 1, ir <= inst, and the next state is DECODE.
REQ-008 In DECODE an illegal class SHALL go to TRAP; any legal class SHALL go to EXEC.
REQ-009 EXEC transitions SHALL be:
- ALU, CMP or JAL go to WB.
- LW or SW go to MEM.
- BR asserts pc_wrt_en = 1 with nextpc_mux = 01 if cmd_flag = 1, else 00, and goes to FETCH.
REQ-010 In MEM the block SHALL hold mem_rd_en (LW) or mem_wrt_en (SW) until mem_ready = 1.
- LW then goes to WB.
- SW asserts pc_wrt_en = 1 with nextpc_mux = 00 in the ready cycle and goes to FETCH.
REQ-011 WB SHALL last exactly one cycle: reg_wrt_en = 1 and pc_wrt_en = 1, then FETCH.
- dstdata_mux is 01 for LW, 10 for JAL, 00 otherwise.
- nextpc_mux is 10 for JAL, 00 otherwise.
REQ-012 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-013 With zero-wait memory, latency SHALL be: BR 3 cycles; ALU, CMP, JAL and SW 4 cycles; LW 5 cycles. Each wait cycle adds one.
REQ-014 At most one of mem_rd_en or mem_wrt_en SHALL be 1 in any cycle; reg_wrt_en SHALL be 1 only in WB.
REQ-015 Enables not explicitly asserted in a state SHALL be 0; mux outputs SHALL follow ir in every state.
REQ-016 TRAP SHALL be absorbing until reset: trap = 1 and all enables 0.

Reset
REQ-017 While reset = 1, the block SHALL force state = FETCH, ir = 0, trap = 0 and all enables 0 (mem_rd_en is gated by reset).
REQ-018 After reset is released, mem_rd_en SHALL be 1 in the first cycle.
REQ-019 Reset asserted mid-instruction SHALL abort it immediately with no register, memory or PC write.

Configuration
REQ-020 With MULTICYCLE_CTRL_MEM_TIMEOUT_EN defined, an 8-bit wait counter SHALL:
- clear on entry to FETCH or MEM;
- increment each cycle that mem_ready = 0 in those states;
- on reaching 255, force TRAP on the next edge without asserting ir_load or pc_wrt_en.
REQ-021 Without MULTICYCLE_CTRL_MEM_TIMEOUT_EN the counter SHALL be absent and waits are unbounded.

Verification
REQ-022 ALU-R (ir = 0xC0123000), mem_ready tied 1 -> states 0, 1, 2, 4, 0; reg_wrt_en and pc_wrt_en high only in the cycle-4 WB; alu_op = 00000; alu_mux = 00.
REQ-023 LW (0x7012000C) with 2 wait cycles in MEM -> mem_rd_en held 3 cycles, then WB with dstdata_mux = 01; total 7 cycles.
REQ-024 BR (0x20120004):
- cmd_flag = 1 -> pc_wrt_en with nextpc_mux = 01 in EXEC, back to FETCH after 3 cycles.
- cmd_flag = 0 -> nextpc_mux = 00.
REQ-025 Illegal op 0xF0000000 -> TRAP (state = 7) after DECODE, trap = 1; a later mem_ready pulse has no effect; reset returns to FETCH.
REQ-026 SW (0x3012000C) with reset asserted during MEM -> mem_wrt_en drops in the same cycle, no pc_wrt_en, state = 0.
REQ-027 With MULTICYCLE_CTRL_MEM_TIMEOUT_EN defined and mem_ready held 0 in FETCH -> TRAP after 256 cycles with ir_load never asserted.
